sa_rf_seq: RTL
==============

Name: sa_rf_seq

Overview:
- Sequencer for the systolic-array register file and PE array.
- Accepts one matrix job via START: takes N row-beats from an upstream stream source and writes them into the RF as WRITE=1 cycles with IDX = row index.
- Then switches the RF to shift mode (WRITE=0) and enables/clears the PE array for the fixed compute window.
- Signals completion with a DONE pulse. Sits between the AXI-side engine logic and the RF/PE array.

Parameters:
- N, 8, array dimension (rows per matrix; RF depth; IDX range 0..N-1).
- DW, 8, element width in bits.
- COMPUTE_CYCLES, 3*N-2, length of the compute window in cycles (22 for N=8).

Ports:
- CLK  in  1  clock, all state on rising edge.
- RSTN  in  1  asynchronous active-low reset.
- START  in  1  job start request, sampled in IDLE only.
- ABORT  in  1  synchronous abort of the current job.
- IN_VALID  in  1  row beat valid.
- IN_READY  out  1  row beat ready.
- IN_DATA  in  2*N*DW  row beat. Bytes 0..N-1 are the X row; bytes N..2N-1 are the (pre-transposed) W row.
- RF_EN  out  1  RF enable.
- RF_WRITE  out  1  RF write (1) / shift-compute (0).
- RF_IDX  out  clog2(N)  RF row index.
- RF_DIN  out  2*N*DW  registered row data; byte j drives DATA_IN_j.
- SA_EN  out  1  PE array accumulate enable.
- SA_CLR  out  1  PE accumulator clear.
- BUSY  out  1  job in progress.
- DONE  out  1  one-cycle job-complete pulse.

Behaviour:
- Reset (RSTN=0, async): state IDLE, row counter 0, cycle counter 0. All outputs 0: IN_READY, RF_EN, RF_WRITE, RF_IDX, RF_DIN, SA_EN, SA_CLR, BUSY, DONE. Reset mid-job discards the job with no DONE.
- All outputs are registered except IN_READY, which is decoded from the state register (1 only in LOAD).
- IDLE:
  - START=1 -> LOAD, row counter 0.
  - IN_VALID is ignored (IN_READY=0).
- LOAD:
  - A beat is accepted on an edge where IN_VALID & IN_READY.
  - In the cycle after acceptance of beat k: RF_EN=1, RF_WRITE=1, RF_IDX=k, RF_DIN=beat k data.
  - In the cycle after an edge with no acceptance: RF_EN=0, RF_WRITE=0. RF_DIN and RF_IDX hold.
  - Gaps in IN_VALID are allowed, with no limit.
  - On acceptance of beat N-1 -> COMPUTE. IN_READY drops the following cycle, so exactly N beats are taken per job.
- COMPUTE:
  - Starts in the cycle immediately after the last write cycle, with no bubble.
  - Lasts exactly COMPUTE_CYCLES consecutive cycles with RF_EN=1, RF_WRITE=0, SA_EN=1.
  - SA_CLR=1 in the first compute cycle only.
  - RF_IDX=0 throughout.
  - Cycle counter runs 0..COMPUTE_CYCLES-1.
- DONE:
  - In the cycle after the last compute cycle: DONE=1 for one cycle; RF_EN, SA_EN, BUSY return to 0; state = IDLE.
  - A START sampled in that cycle is accepted (back-to-back jobs).
- BUSY: 1 from the cycle after START is accepted through the last compute cycle.
- START while BUSY is ignored, not queued.
- ABORT:
  - ABORT=1 in LOAD or COMPUTE -> IDLE at the next edge. The following cycle has all outputs 0 and no DONE.
  - ABORT beats a simultaneous handshake; that beat is not written and counts as not accepted, because IN_READY is forced to 0 when ABORT=1.
  - ABORT=1 in IDLE has priority over START: the job does not start.
- Counters never wrap within a job. Both counters clear on entry to LOAD and on abort.

Test Plan:
- Back-to-back load: START at cycle 0 and IN_VALID=1 continuously with beats 0..7 (X bytes=k, W bytes=16+k).
  - Write cycles 2..9 show IDX=0..7 and matching RF_DIN.
  - Compute cycles 10..31: SA_EN=1, WRITE=0, SA_CLR only at cycle 10.
  - DONE=1 at cycle 32 only; exactly 8 handshakes occur.
- Gapped valid: IN_VALID toggles 1/0 during LOAD.
  - RF_EN=0 in each gap cycle, RF_IDX holds, and the sequence of written IDX is still 0..7.
  - Compute starts the cycle after the 8th write.
- START pulsed during COMPUTE -> ignored: no second job, and BUSY=0 after the single DONE. START in the DONE cycle -> a new LOAD begins and IN_READY=1 the next cycle.
- ABORT at compute cycle 5 -> next cycle: SA_EN=0, RF_EN=0, BUSY=0, and no DONE ever. A following START runs a full job normally.
- RSTN low asynchronously after beat 3 in LOAD -> all outputs 0 immediately. After release, IN_VALID is ignored until START.
- ABORT and a beat handshake in the same cycle -> no write cycle for that beat, and state = IDLE.

Source files
------------

// File: rtl/sa_rf_seq.sv
// sa_rf_seq: sequences one matrix job into the systolic-array register file.
// It takes N row beats into the RF and then runs the fixed-length PE compute
// window, ending with a one-cycle DONE pulse.
module sa_rf_seq #(
   parameter int unsigned N              = 8,
   parameter int unsigned DW             = 8,
   parameter int unsigned COMPUTE_CYCLES = 3 * N - 2
) (
   input  logic                   CLK,
   input  logic                   RSTN,
   input  logic                   START,
   input  logic                   ABORT,
   input  logic                   IN_VALID,
   output logic                   IN_READY,
   input  logic [2*N*DW-1:0]      IN_DATA,
   output logic                   RF_EN,
   output logic                   RF_WRITE,
   output logic [$clog2(N)-1:0]   RF_IDX,
   output logic [2*N*DW-1:0]      RF_DIN,
   output logic                   SA_EN,
   output logic                   SA_CLR,
   output logic                   BUSY,
   output logic                   DONE
);

   localparam int unsigned IW = $clog2(N);
   localparam int unsigned CW = $clog2(COMPUTE_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LOAD    = 2'd1,
      S_COMPUTE = 2'd2
   } state_t;

   state_t          state;
   logic [IW-1:0]   row_cnt;
   logic [CW-1:0]   cyc_cnt;
   logic            accept;

   // Ready only while loading; an abort suppresses the handshake in that cycle.
   assign IN_READY = (state == S_LOAD) && !ABORT;
   assign accept   = IN_VALID && IN_READY;

   // Job sequencer: state, counters and all registered outputs.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state    <= S_IDLE;
         row_cnt  <= '0;
         cyc_cnt  <= '0;
         RF_EN    <= 1'b0;
         RF_WRITE <= 1'b0;
         RF_IDX   <= '0;
         RF_DIN   <= '0;
         SA_EN    <= 1'b0;
         SA_CLR   <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
      end else begin
         RF_EN    <= 1'b0;
         RF_WRITE <= 1'b0;
         SA_EN    <= 1'b0;
         SA_CLR   <= 1'b0;
         DONE     <= 1'b0;
         if (ABORT) begin
            state   <= S_IDLE;
            row_cnt <= '0;
            cyc_cnt <= '0;
            RF_IDX  <= '0;
            RF_DIN  <= '0;
            BUSY    <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (START) begin
                     state   <= S_LOAD;
                     row_cnt <= '0;
                     cyc_cnt <= '0;
                     BUSY    <= 1'b1;
                  end
               end
               S_LOAD: begin
                  if (accept) begin
                     RF_EN    <= 1'b1;
                     RF_WRITE <= 1'b1;
                     RF_IDX   <= row_cnt;
                     RF_DIN   <= IN_DATA;
                     if (row_cnt == IW'(N - 1)) begin
                        state   <= S_COMPUTE;
                        cyc_cnt <= '0;
                     end else begin
                        row_cnt <= row_cnt + IW'(1);
                     end
                  end
               end
               S_COMPUTE: begin
                  if (cyc_cnt != CW'(COMPUTE_CYCLES)) begin
                     RF_EN   <= 1'b1;
                     SA_EN   <= 1'b1;
                     SA_CLR  <= (cyc_cnt == '0);
                     RF_IDX  <= '0;
                     cyc_cnt <= cyc_cnt + CW'(1);
                  end else begin
                     DONE  <= 1'b1;
                     BUSY  <= 1'b0;
                     state <= S_IDLE;
                  end
               end
               default: begin
                  state <= S_IDLE;
                  BUSY  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
